// File: rtl/nf_dm_resp.sv
// Data-memory responder: a word-organised RAM behind the core's req/ack data bus.
// It serves byte, halfword and word accesses and inserts WAIT_CYCLES wait states before the acknowledge.
module nf_dm_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr_dm,
  input  logic [31:0] wd_dm,
  input  logic        we_dm,
  input  logic [1:0]  size_dm,
  input  logic        req_dm,
  output logic        req_ack_dm,
  output logic [31:0] rd_dm,
  output logic        misalign_dm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic [31:0]   wd_q;
  logic          we_q;
  logic          mis_q;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] in_idx;
  logic [1:0]    in_lane;
  logic          in_mis;
  logic [AW-1:0] cur_idx;
  logic [1:0]    cur_lane;
  logic [1:0]    cur_size;
  logic          cur_we;
  logic          cur_mis;
  logic          enter_ack;
  logic [31:0]   word_sh;
  logic [31:0]   rdata_d;
  logic [31:0]   wdata_st;
  logic [3:0]    be_st;
  logic          unused_addr;

  assign unused_addr = ^addr_dm[31:AW+2];

  // Request decode: force alignment and flag any forced-off address bit.
  always_comb begin
    in_idx  = addr_dm[AW+1:2];
    in_lane = 2'b00;
    in_mis  = 1'b0;
    case (size_dm)
      2'd0:    in_lane = addr_dm[1:0];
      2'd1: begin
        in_lane = {addr_dm[1], 1'b0};
        in_mis  = addr_dm[0];
      end
      default: in_mis = |addr_dm[1:0];
    endcase
  end

  // With zero wait states ACK is entered straight from IDLE, so the read uses the live request.
  always_comb begin
    cur_idx  = idx_q;
    cur_lane = lane_q;
    cur_size = size_q;
    cur_we   = we_q;
    cur_mis  = mis_q;
    if (state_q == IDLE) begin
      cur_idx  = in_idx;
      cur_lane = in_lane;
      cur_size = size_dm;
      cur_we   = we_dm;
      cur_mis  = in_mis;
    end
    enter_ack = ((state_q == IDLE) && req_dm && (WAIT_CYCLES == 0)) ||
                ((state_q == WAIT) && (cnt_q == '0));
    word_sh = mem_q[cur_idx] >> {cur_lane, 3'b000};
    case (cur_size)
      2'd0:    rdata_d = {24'h0, word_sh[7:0]};
      2'd1:    rdata_d = {16'h0, word_sh[15:0]};
      default: rdata_d = word_sh;
    endcase
  end

  always_comb begin
    wdata_st = wd_q << {lane_q, 3'b000};
    case (size_q)
      2'd0:    be_st = 4'b0001 << lane_q;
      2'd1:    be_st = 4'b0011 << lane_q;
      default: be_st = 4'b1111;
    endcase
  end

  // Store commits on the edge leaving ACK; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ACK && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_st[b]) mem_q[idx_q][8*b +: 8] <= wdata_st[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      wd_q        <= '0;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      req_ack_dm  <= 1'b0;
      rd_dm       <= '0;
      misalign_dm <= 1'b0;
    end else begin
      req_ack_dm  <= 1'b0;
      misalign_dm <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_dm) begin
            idx_q   <= in_idx;
            lane_q  <= in_lane;
            size_q  <= size_dm;
            wd_q    <= wd_dm;
            we_q    <= we_dm;
            mis_q   <= in_mis;
            cnt_q   <= CNT_LOAD;
            state_q <= (WAIT_CYCLES == 0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= ACK;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        default: state_q <= IDLE;
      endcase
      if (enter_ack) begin
        req_ack_dm  <= 1'b1;
        misalign_dm <= cur_mis;
        if (!cur_we) rd_dm <= rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_nf_dm_resp.sv
// Bench for nf_dm_resp: one instance with zero wait states and one with three,
// checked against a queue of expected responses.
module tb_nf_dm_resp;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
  } step_t;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        chk_rd;
    int          lat;
  } exp_t;

  logic        clk, reset;
  logic [31:0] addr0, wd0, addr3, wd3;
  logic        we0, we3, req0, req3;
  logic [1:0]  sz0, sz3;
  logic        ack0, ack3, mis0, mis3;
  logic [31:0] rd0, rd3;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  nf_dm_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .addr_dm(addr0), .wd_dm(wd0), .we_dm(we0), .size_dm(sz0),
    .req_dm(req0), .req_ack_dm(ack0), .rd_dm(rd0), .misalign_dm(mis0));

  nf_dm_resp #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .addr_dm(addr3), .wd_dm(wd3), .we_dm(we3), .size_dm(sz3),
    .req_dm(req3), .req_ack_dm(ack3), .rd_dm(rd3), .misalign_dm(mis3));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input int d, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd, input logic req);
    if (d == 0) begin
      we0 = we; sz0 = sz; addr0 = a; wd0 = wd; req0 = req;
    end else begin
      we3 = we; sz3 = sz; addr3 = a; wd3 = wd; req3 = req;
    end
  endtask

  // One bus transaction; starts just after a rising edge and returns just after one.
  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] alt, input bit use_alt,
                     output logic [31:0] rd, output logic mis, output int lat,
                     output int acyc, output bit ok);
    logic ack;
    rd = '0; mis = 1'b0; lat = -1; acyc = -1; ok = 1'b0;
    drive(d, we, sz, a, wd, 1'b1);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      ack = (d == 0) ? ack0 : ack3;
      if (ack) begin
        rd   = (d == 0) ? rd0 : rd3;
        mis  = (d == 0) ? mis0 : mis3;
        lat  = n;
        acyc = cyc;
        ok   = 1'b1;
        break;
      end
      if (use_alt && n == 1) begin
        if (d == 0) addr0 = alt; else addr3 = alt;
      end
    end
    @(posedge clk);
    #1;
    drive(d, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if ({ack0, mis0, rd0} !== 34'h0) begin
      n_fail++; $display("FAIL reset_u0: got ack=%b mis=%b rd=%h, want all zero", ack0, mis0, rd0);
    end
    n_checks++;
    if ({ack3, mis3, rd3} !== 34'h0) begin
      n_fail++; $display("FAIL reset_u3: got ack=%b mis=%b rd=%h, want all zero", ack3, mis3, rd3);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    step_t st [0:5];
    exp_t e;
    logic [31:0] rd; logic mis; int lat, acyc; bit ok;
    st = '{'{1'b1, 2'd2, 32'h10, 32'h11223344, 32'h0,        1'b0},
           '{1'b0, 2'd2, 32'h10, 32'h0,        32'h11223344, 1'b0},
           '{1'b1, 2'd0, 32'h13, 32'h000000AB, 32'h0,        1'b0},
           '{1'b0, 2'd2, 32'h10, 32'h0,        32'hAB223344, 1'b0},
           '{1'b0, 2'd0, 32'h12, 32'h0,        32'h00000022, 1'b0},
           '{1'b0, 2'd1, 32'h12, 32'h0,        32'h0000AB22, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{st[i].rd, st[i].mis, !st[i].we, 1});
      txn(0, st[i].we, st[i].sz, st[i].a, st[i].wd, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic[%0d] ack: timed out, want one", i); continue; end
      n_checks++;
      if (lat !== e.lat) begin n_fail++; $display("FAIL basic[%0d] latency: got %0d, want %0d", i, lat, e.lat); end
      n_checks++;
      if (mis !== e.mis) begin n_fail++; $display("FAIL basic[%0d] misalign: got %b, want %b", i, mis, e.mis); end
      if (e.chk_rd) begin
        n_checks++;
        if (rd !== e.rd) begin n_fail++; $display("FAIL basic[%0d] rd: got %h, want %h", i, rd, e.rd); end
      end
    end
  endtask

  task automatic test_misalign;
    step_t st [0:4];
    exp_t e;
    logic [31:0] rd; logic mis; int lat, acyc; bit ok;
    st = '{'{1'b0, 2'd2, 32'h11, 32'h0,        32'hAB223344, 1'b1},
           '{1'b1, 2'd1, 32'h13, 32'h0000BEEF, 32'h0,        1'b1},
           '{1'b0, 2'd2, 32'h10, 32'h0,        32'hBEEF3344, 1'b0},
           '{1'b0, 2'd1, 32'h11, 32'h0,        32'h00003344, 1'b1},
           '{1'b0, 2'd3, 32'h12, 32'h0,        32'hBEEF3344, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{st[i].rd, st[i].mis, !st[i].we, 1});
      txn(0, st[i].we, st[i].sz, st[i].a, st[i].wd, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL misalign[%0d] ack: timed out, want one", i); continue; end
      n_checks++;
      if (mis !== e.mis) begin n_fail++; $display("FAIL misalign[%0d] misalign: got %b, want %b", i, mis, e.mis); end
      if (e.chk_rd) begin
        n_checks++;
        if (rd !== e.rd) begin n_fail++; $display("FAIL misalign[%0d] rd: got %h, want %h", i, rd, e.rd); end
      end
    end
  endtask

  task automatic test_wrap;
    step_t st [0:2];
    exp_t e;
    logic [31:0] rd; logic mis; int lat, acyc; bit ok;
    st = '{'{1'b1, 2'd2, 32'h00001000, 32'hCAFEF00D, 32'h0,        1'b0},
           '{1'b0, 2'd2, 32'h00000000, 32'h0,        32'hCAFEF00D, 1'b0},
           '{1'b0, 2'd2, 32'hFFFFF010, 32'h0,        32'hBEEF3344, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{st[i].rd, st[i].mis, !st[i].we, 1});
      txn(0, st[i].we, st[i].sz, st[i].a, st[i].wd, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL wrap[%0d] ack: timed out, want one", i); continue; end
      if (e.chk_rd) begin
        n_checks++;
        if (rd !== e.rd) begin n_fail++; $display("FAIL wrap[%0d] rd: got %h, want %h", i, rd, e.rd); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic mis; int lat, c1, c2; bit ok1, ok2;
    txn(0, 1'b1, 2'd2, 32'h30, 32'h5A5AA5A5, 32'h0, 1'b0, rd, mis, lat, c1, ok1);
    exp_q.push_back('{32'h5A5AA5A5, 1'b0, 1'b1, 1});
    txn(0, 1'b0, 2'd2, 32'h30, 32'h0, 32'h0, 1'b0, rd, mis, lat, c2, ok2);
    begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (!(ok1 && ok2) || (c2 - c1) != 2) begin
        n_fail++; $display("FAIL b2b ack spacing: got %0d cycles, want 2", c2 - c1);
      end
      n_checks++;
      if (rd !== e.rd) begin n_fail++; $display("FAIL b2b rd: got %h, want %h", rd, e.rd); end
    end
  endtask

  task automatic test_wait_states;
    exp_t e;
    logic [31:0] rd; logic mis; int lat, acyc; bit ok;
    txn(3, 1'b1, 2'd2, 32'h10, 32'hAB223344, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
    n_checks++;
    if (!ok || lat != 4) begin n_fail++; $display("FAIL wait_store latency: got %0d, want 4", lat); end
    txn(3, 1'b1, 2'd2, 32'h40, 32'h55555555, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
    exp_q.push_back('{32'hAB223344, 1'b0, 1'b1, 4});
    txn(3, 1'b0, 2'd2, 32'h10, 32'h0, 32'h40, 1'b1, rd, mis, lat, acyc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || lat !== e.lat) begin n_fail++; $display("FAIL wait_load latency: got %0d, want %0d", lat, e.lat); end
    n_checks++;
    if (rd !== e.rd) begin n_fail++; $display("FAIL wait_load rd: got %h, want %h", rd, e.rd); end
    @(negedge clk);
    n_checks++;
    if (ack3 !== 1'b0) begin n_fail++; $display("FAIL wait_ack_width: got ack=%b after ack cycle, want 0", ack3); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic [31:0] rd; logic mis; int lat, acyc; bit ok;
    txn(3, 1'b1, 2'd2, 32'h20, 32'h01234567, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
    txn(3, 1'b0, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
    n_checks++;
    if (!ok || rd !== 32'h01234567) begin n_fail++; $display("FAIL rst_pre rd: got %h, want 01234567", rd); end
    drive(3, 1'b1, 2'd2, 32'h20, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({ack3, mis3, rd3} !== 34'h0) begin
      n_fail++; $display("FAIL rst_mid outputs: got ack=%b mis=%b rd=%h, want all zero", ack3, mis3, rd3);
    end
    drive(3, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    exp_q.push_back('{32'h01234567, 1'b0, 1'b1, 4});
    txn(3, 1'b0, 2'd2, 32'h20, 32'h0, 32'h0, 1'b0, rd, mis, lat, acyc, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || rd !== e.rd) begin n_fail++; $display("FAIL rst_post rd: got %h, want %h", rd, e.rd); end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    drive(3, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_basic();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_wait_states();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
